// File: rtl/rfic_ctrl_seq.sv
// AD9361 control sequencer: per-RFIC reset pulse generation, multi-chip sync
// strobe sequencing and synchronised CTRL_OUT status monitoring.
module rfic_ctrl_seq #(
   parameter int NUM_RFIC     = 2,
   parameter int RESET_CYCLES = 1000,
   parameter int SYNC_HIGH    = 4,
   parameter int SYNC_GAP     = 16,
   parameter int SYNC_PULSES  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_RFIC-1:0]   resetb_req,
   input  logic                  sync_req,
   input  logic [8*NUM_RFIC-1:0] gpio_status,
   input  logic [NUM_RFIC-1:0]   status_chg_clr,
   output logic [NUM_RFIC-1:0]   gpio_resetb,
   output logic                  mcs_sync,
   output logic                  sync_busy,
   output logic                  sync_err,
   output logic [8*NUM_RFIC-1:0] status_sync,
   output logic [NUM_RFIC-1:0]   status_chg
);

   localparam int CW   = $clog2(RESET_CYCLES + 1);
   localparam int TMAX = (SYNC_HIGH > SYNC_GAP) ? SYNC_HIGH : SYNC_GAP;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [CW-1:0] RST_LOAD  = CW'(RESET_CYCLES);
   localparam logic [TW-1:0] HIGH_LOAD = TW'(SYNC_HIGH);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(SYNC_GAP);
   localparam logic [3:0]    PULSES    = 4'(SYNC_PULSES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [NUM_RFIC-1:0] resetb_req_q;
   logic                sync_req_q;
   logic                rst_q;
   logic [NUM_RFIC-1:0] resetb_edge;
   logic                sync_edge;

   logic [CW-1:0]       rst_cnt      [NUM_RFIC];
   logic [CW-1:0]       rst_cnt_next [NUM_RFIC];

   logic [1:0]          state, state_next;
   logic [TW-1:0]       timer, timer_next;
   logic [3:0]          pulse_cnt, pulse_next;
   logic                accept, abort;

   logic [8*NUM_RFIC-1:0] status_meta;
   logic [NUM_RFIC-1:0]   status_diff;

   // rst_q masks the first cycle after reset so a request held high through
   // reset is not mistaken for a fresh edge
   always_ff @(posedge clk) begin
      if (rst) begin
         resetb_req_q <= '0;
         sync_req_q   <= 1'b0;
         rst_q        <= 1'b1;
      end else begin
         resetb_req_q <= resetb_req;
         sync_req_q   <= sync_req;
         rst_q        <= 1'b0;
      end
   end

   assign resetb_edge = resetb_req & ~resetb_req_q & {NUM_RFIC{~rst_q}};
   assign sync_edge   = sync_req & ~sync_req_q & ~rst_q;

   always_comb begin
      for (int i = 0; i < NUM_RFIC; i++) begin
         if (resetb_edge[i])
            rst_cnt_next[i] = RST_LOAD;
         else if (rst_cnt[i] != '0)
            rst_cnt_next[i] = rst_cnt[i] - CW'(1);
         else
            rst_cnt_next[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_RFIC; i++) rst_cnt[i] <= RST_LOAD;
         gpio_resetb <= '0;
      end else begin
         for (int i = 0; i < NUM_RFIC; i++) begin
            rst_cnt[i]     <= rst_cnt_next[i];
            gpio_resetb[i] <= (rst_cnt_next[i] == '0);
         end
      end
   end

   // A sync may only start once every RFIC is out of reset and none is being
   // reset this very cycle; a new reset request kills a running sequence
   assign accept = (state == ST_IDLE) && (&gpio_resetb) && !(|resetb_edge) && sync_edge;
   assign abort  = (state != ST_IDLE) && (|resetb_edge);

   always_comb begin
      state_next = state;
      timer_next = timer;
      pulse_next = pulse_cnt;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next = ST_HIGH;
               timer_next = HIGH_LOAD;
               pulse_next = 4'd0;
            end
         end
         ST_HIGH: begin
            if (timer == TW'(1)) begin
               state_next = ST_GAP;
               timer_next = GAP_LOAD;
               pulse_next = pulse_cnt + 4'd1;
            end else begin
               timer_next = timer - TW'(1);
            end
         end
         ST_GAP: begin
            if (timer == TW'(1)) begin
               if (pulse_cnt < PULSES) begin
                  state_next = ST_HIGH;
                  timer_next = HIGH_LOAD;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               timer_next = timer - TW'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (abort) state_next = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         timer     <= '0;
         pulse_cnt <= 4'd0;
         mcs_sync  <= 1'b0;
         sync_busy <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         state     <= state_next;
         timer     <= timer_next;
         pulse_cnt <= pulse_next;
         mcs_sync  <= (state_next == ST_HIGH);
         sync_busy <= (state_next != ST_IDLE);
         sync_err  <= sync_edge && !accept;
      end
   end

   // Change is flagged on the same edge the synchronised byte takes its new value
   always_comb begin
      for (int i = 0; i < NUM_RFIC; i++)
         status_diff[i] = (status_meta[8*i +: 8] != status_sync[8*i +: 8]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_meta <= '0;
         status_sync <= '0;
         status_chg  <= '0;
      end else begin
         status_meta <= gpio_status;
         status_sync <= status_meta;
         status_chg  <= status_diff | (status_chg & ~status_chg_clr);
      end
   end

endmodule

// File: tb/tb_rfic_ctrl_seq.sv
// Testbench for rfic_ctrl_seq: directed scenarios followed by random traffic,
// every cycle compared against a timeline-based reference model.
module tb_rfic_ctrl_seq;

   localparam int N   = 2;
   localparam int R   = 8;
   localparam int H   = 4;
   localparam int G   = 16;
   localparam int P   = 2;
   localparam int PER = H + G;
   localparam int L   = P * PER;

   logic        clk;
   logic        rst;
   logic [1:0]  resetb_req;
   logic        sync_req;
   logic [15:0] gpio_status;
   logic [1:0]  status_chg_clr;
   logic [1:0]  gpio_resetb;
   logic        mcs_sync;
   logic        sync_busy;
   logic        sync_err;
   logic [15:0] status_sync;
   logic [1:0]  status_chg;

   int vectors;
   int miscompares;

   // reference model: outputs expressed as timelines over edge numbers
   int          cyc;
   int          high_at [2];
   bit          seq_on;
   int          seq_start;
   logic        exp_err;
   logic [15:0] m_s1, m_s2;
   logic [1:0]  m_chg;
   logic [1:0]  m_prev_rreq;
   logic        m_prev_sreq;
   logic        m_prev_rst;

   rfic_ctrl_seq #(
      .NUM_RFIC(N), .RESET_CYCLES(R), .SYNC_HIGH(H), .SYNC_GAP(G), .SYNC_PULSES(P)
   ) dut (
      .clk(clk), .rst(rst), .resetb_req(resetb_req), .sync_req(sync_req),
      .gpio_status(gpio_status), .status_chg_clr(status_chg_clr),
      .gpio_resetb(gpio_resetb), .mcs_sync(mcs_sync), .sync_busy(sync_busy),
      .sync_err(sync_err), .status_sync(status_sync), .status_chg(status_chg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit in_seq(input int m);
      return seq_on && (m >= seq_start) && (m < seq_start + L);
   endfunction

   function automatic bit exp_mcs(input int m);
      return in_seq(m) && (((m - seq_start) % PER) < H);
   endfunction

   task automatic modelEdge(input logic r, input logic [1:0] rreq, input logic sreq,
                            input logic [15:0] gst, input logic [1:0] clr);
      logic [1:0] redge;
      logic       sedge;
      bit         busy_prev, all_high_prev, acc;
      if (r) begin
         for (int i = 0; i < N; i++) high_at[i] = cyc + R;
         seq_on      = 0;
         exp_err     = 1'b0;
         m_s1        = '0;
         m_s2        = '0;
         m_chg       = '0;
         m_prev_rreq = '0;
         m_prev_sreq = 1'b0;
         m_prev_rst  = 1'b1;
      end else begin
         redge         = rreq & ~m_prev_rreq & {2{~m_prev_rst}};
         sedge         = sreq & ~m_prev_sreq & ~m_prev_rst;
         busy_prev     = in_seq(cyc - 1);
         all_high_prev = (cyc - 1 >= high_at[0]) && (cyc - 1 >= high_at[1]);
         acc           = !busy_prev && all_high_prev && (redge == 2'b00) && sedge;
         if (busy_prev && (redge != 2'b00)) seq_on = 0;
         for (int i = 0; i < N; i++) if (redge[i]) high_at[i] = cyc + R;
         if (acc) begin
            seq_on    = 1;
            seq_start = cyc;
         end
         exp_err = sedge && !acc;
         for (int i = 0; i < N; i++)
            m_chg[i] = (m_s1[8*i +: 8] != m_s2[8*i +: 8]) || (m_chg[i] && !clr[i]);
         m_s2        = m_s1;
         m_s1        = gst;
         m_prev_rreq = rreq;
         m_prev_sreq = sreq;
         m_prev_rst  = 1'b0;
      end
   endtask

   task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic checkOutput();
      logic [1:0] e_rb;
      for (int i = 0; i < N; i++) e_rb[i] = (cyc >= high_at[i]);
      cmp("gpio_resetb", 16'(gpio_resetb), 16'(e_rb));
      cmp("mcs_sync",    16'(mcs_sync),    16'(exp_mcs(cyc)));
      cmp("sync_busy",   16'(sync_busy),   16'(in_seq(cyc)));
      cmp("sync_err",    16'(sync_err),    16'(exp_err));
      cmp("status_sync", status_sync,      m_s2);
      cmp("status_chg",  16'(status_chg),  16'(m_chg));
   endtask

   // drive on the falling edge, advance the model on the rising edge, check 1ns later
   task automatic applyStimulus(input logic r, input logic [1:0] rreq, input logic sreq,
                                input logic [15:0] gst, input logic [1:0] clr);
      @(negedge clk);
      rst            = r;
      resetb_req     = rreq;
      sync_req       = sreq;
      gpio_status    = gst;
      status_chg_clr = clr;
      @(posedge clk);
      cyc++;
      modelEdge(r, rreq, sreq, gst, clr);
      #1;
      checkOutput();
   endtask

   initial begin
      int          err_cnt, busy_cnt, mcs_cnt, low0_cnt, low1_cnt;
      logic        r_r, r_s;
      logic [1:0]  r_rreq, r_clr;
      logic [15:0] r_gst;

      vectors        = 0;
      miscompares    = 0;
      cyc            = 0;
      rst            = 1'b1;
      resetb_req     = '0;
      sync_req       = 1'b0;
      gpio_status    = '0;
      status_chg_clr = '0;

      // power-on reset, then a sync request while the RFICs are still held in reset
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 2'b00, 1'b0, 16'h0000, 2'b00);
      err_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b0, 2'b00, (k == 2 || k == 3), 16'h0000, 2'b00);
         if (sync_err) err_cnt++;
      end
      cmp("por_sync_err_pulses", 16'(err_cnt), 16'd1);
      cmp("por_resetb_released", 16'(gpio_resetb), 16'h0003);

      // full sync sequence with a rejected second request at cycle 10
      busy_cnt = 0;
      mcs_cnt  = 0;
      err_cnt  = 0;
      for (int k = 0; k < 50; k++) begin
         applyStimulus(1'b0, 2'b00, (k == 0 || k == 10), 16'h0000, 2'b00);
         if (sync_busy) busy_cnt++;
         if (mcs_sync) mcs_cnt++;
         if (sync_err) err_cnt++;
      end
      cmp("seq_busy_cycles", 16'(busy_cnt), 16'(L));
      cmp("seq_mcs_cycles",  16'(mcs_cnt),  16'(P * H));
      cmp("seq_err_pulses",  16'(err_cnt),  16'd1);

      // retriggered reset on RFIC 1
      low0_cnt = 0;
      low1_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, (k == 0 || k == 5) ? 2'b10 : 2'b00, 1'b0, 16'h0000, 2'b00);
         if (!gpio_resetb[0]) low0_cnt++;
         if (!gpio_resetb[1]) low1_cnt++;
      end
      cmp("retrig_low_cycles_rfic1", 16'(low1_cnt), 16'd13);
      cmp("retrig_low_cycles_rfic0", 16'(low0_cnt), 16'd0);

      // reset request on RFIC 0 during the HIGH phase aborts the sequence
      low0_cnt = 0;
      for (int k = 0; k < 14; k++) begin
         applyStimulus(1'b0, (k == 2) ? 2'b01 : 2'b00, (k == 0), 16'h0000, 2'b00);
         if (k == 2) cmp("abort_mcs_low", 16'(mcs_sync), 16'd0);
         if (!gpio_resetb[0]) low0_cnt++;
      end
      cmp("abort_rfic0_low_cycles", 16'(low0_cnt), 16'(R));

      // status change, change coinciding with clear, then clear alone
      applyStimulus(1'b0, 2'b00, 1'b0, 16'h5A00, 2'b00);
      applyStimulus(1'b0, 2'b00, 1'b0, 16'h5A00, 2'b00);
      cmp("status_chg_set", 16'(status_chg), 16'h0002);
      applyStimulus(1'b0, 2'b00, 1'b0, 16'h5A00, 2'b00);
      applyStimulus(1'b0, 2'b00, 1'b0, 16'h5B00, 2'b00);
      applyStimulus(1'b0, 2'b00, 1'b0, 16'h5B00, 2'b10);
      cmp("status_chg_set_wins", 16'(status_chg), 16'h0002);
      applyStimulus(1'b0, 2'b00, 1'b0, 16'h5B00, 2'b10);
      cmp("status_chg_cleared", 16'(status_chg), 16'h0000);
      applyStimulus(1'b0, 2'b00, 1'b0, 16'h5B00, 2'b00);

      // reset asserted in the middle of a sync sequence
      for (int k = 0; k < 24; k++)
         applyStimulus((k == 6 || k == 7), 2'b00, (k == 0), 16'h5B00, 2'b00);

      // random traffic
      r_rreq = 2'b00;
      r_s    = 1'b0;
      r_gst  = 16'h5B00;
      for (int k = 0; k < 600; k++) begin
         r_r = ($urandom_range(199) == 0);
         for (int i = 0; i < N; i++)
            if ($urandom_range(23) == 0) r_rreq[i] = ~r_rreq[i];
         if ($urandom_range(3) == 0) r_s = ~r_s;
         if ($urandom_range(3) == 0) r_gst = 16'($urandom);
         r_clr = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b00;
         applyStimulus(r_r, r_rreq, r_s, r_gst, r_clr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rfic_ctrl_seq.md
RFIC_CTRL_SEQ -- requirements
Module: rfic_ctrl_seq

Interface
REQ-001 Parameter NUM_RFIC, default 2, number of AD9361 devices controlled (legal 1..4).
REQ-002 Parameter RESET_CYCLES, default 1000, width of the RFIC resetb low pulse in clk cycles (legal >= 2).
REQ-003 Parameter SYNC_HIGH, default 4, mcs_sync high time per pulse in clk cycles (legal >= 1).
REQ-004 Parameter SYNC_GAP, default 16, mcs_sync low time between pulses in clk cycles (legal >= 1).
REQ-005 Parameter SYNC_PULSES, default 2, number of mcs_sync pulses per sync request (legal 1..8).
REQ-006 clk  in  1  single block clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 resetb_req  in  NUM_RFIC  per-RFIC reset request from EMIO GPIO, synchronous to clk, edge-triggered on rising edge.
REQ-009 sync_req  in  1  MCS sync request from EMIO GPIO, synchronous to clk, rising-edge triggered.
REQ-010 gpio_status  in  8*NUM_RFIC  CTRL_OUT from RFICs, asynchronous to clk; RFIC i on bits [8i+7:8i].
REQ-011 status_chg_clr  in  NUM_RFIC  per-RFIC clear of status_chg, level, synchronous.
REQ-012 gpio_resetb  out  NUM_RFIC  active-low RFIC reset, registered.
REQ-013 mcs_sync  out  1  multi-chip sync strobe to all RFICs, registered.
REQ-014 sync_busy  out  1  high while the MCS sequence runs.
REQ-015 sync_err  out  1  one-cycle pulse when a sync request is rejected.
REQ-016 status_sync  out  8*NUM_RFIC  gpio_status after 2-flop synchroniser.
REQ-017 status_chg  out  NUM_RFIC  sticky flag: RFIC i status changed since last clear.

Function
REQ-018 Edge detect: resetb_req and sync_req each registered once; request edge = current high AND registered value low; no edge on the cycle rst deasserts.
REQ-019 Per RFIC i, an independent down-counter (width ceil(log2(RESET_CYCLES+1))) drives gpio_resetb[i] low while nonzero.
REQ-020 Rising edge of resetb_req[i] reloads counter i to RESET_CYCLES; gpio_resetb[i] goes low the cycle after the edge and returns high exactly RESET_CYCLES cycles later.
REQ-021 Edge on resetb_req[i] while its counter is active restarts the count (retrigger); other RFICs unaffected.
REQ-022 MCS FSM states: IDLE, HIGH, GAP; sync_busy = (state != IDLE); mcs_sync = (state == HIGH), registered.
REQ-023 IDLE -> HIGH on sync_req edge when all gpio_resetb are high; pulse counter cleared, timer loaded SYNC_HIGH.
REQ-024 HIGH -> GAP when timer expires (SYNC_HIGH cycles in HIGH); pulse counter increments.
REQ-025 GAP -> HIGH after SYNC_GAP cycles if pulse count < SYNC_PULSES, else GAP -> IDLE after SYNC_GAP cycles.
REQ-026 Total sequence: SYNC_PULSES*(SYNC_HIGH+SYNC_GAP) cycles of sync_busy high.
REQ-027 sync_req edge in IDLE while any gpio_resetb low: stay IDLE, sync_err high for exactly one cycle.
REQ-028 sync_req edge while sync_busy: ignored, sync_err high one cycle, sequence continues unchanged.
REQ-029 resetb_req edge for any RFIC while sync_busy: accepted; FSM aborts to IDLE next cycle, mcs_sync low next cycle, no sync_err.
REQ-030 status_sync = 2-flop synchronised gpio_status; status_chg[i] sets when status_sync byte i differs from its value one cycle earlier.
REQ-031 Simultaneous status change and status_chg_clr[i]: set wins, status_chg[i] stays 1.
REQ-032 status_chg_clr[i] with no change: status_chg[i] 0 next cycle.

Reset
REQ-033 During rst: gpio_resetb all 0, every reset counter loaded RESET_CYCLES, FSM IDLE, mcs_sync 0, sync_busy 0, sync_err 0, status_sync 0, status_chg 0, edge registers 0.
REQ-034 After rst deasserts, gpio_resetb all return high RESET_CYCLES cycles later (power-on reset pulse); sync requests during this window are rejected per REQ-027.
REQ-035 rst asserted mid-sequence or mid-reset-pulse overrides all state on the next edge.

Verification
REQ-036 RESET_CYCLES=8: release rst -> gpio_resetb=2'b00 for 8 cycles, then 2'b11; sync_req edge at cycle 3 -> sync_err one-cycle pulse, mcs_sync stays 0.
REQ-037 Defaults, idle: sync_req edge -> mcs_sync 4 high / 16 low twice, sync_busy high 40 cycles, second sync_req at cycle 10 -> sync_err pulse, sequence length unchanged.
REQ-038 resetb_req[1] edge, then second edge 5 cycles later (RESET_CYCLES=8) -> gpio_resetb[1] low 13 cycles total, gpio_resetb[0] stays 1.
REQ-039 resetb_req[0] edge during HIGH state -> mcs_sync and sync_busy 0 next cycle, gpio_resetb[0] low 8 cycles.
REQ-040 gpio_status[15:8] 0x00->0x5A -> status_sync updates after 2 cycles, status_chg=2'b10; clr[1] on same cycle as next change 0x5A->0x5B -> status_chg[1] stays 1; clr alone -> 0.
